// File: rtl/rocket_collision_ctl.sv
// Rocket collision/landing detector: scans each frame's pixel stream against the
// rocket bounding box and publishes frame-stable collision and landed flags.
module rocket_collision_ctl #(
    parameter int unsigned ROCKET_HIGH  = 64,
    parameter int unsigned ROCKET_WIDTH = 48,
    parameter int unsigned EDGE         = 4,
    parameter int unsigned PAD_MIN_HITS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [10:0] hcount,
    input  logic [10:0] vcount,
    input  logic        vblnk,
    input  logic        terrain,
    input  logic        pad,
    input  logic        started,
    input  logic [11:0] x_pos,
    input  logic [11:0] y_pos,
    output logic        colission_up,
    output logic        colission_down,
    output logic        colission_left,
    output logic        colission_right,
    output logic        landed
);

    localparam int unsigned PW = 12;
    localparam int unsigned SW = 13;
    localparam int unsigned CW = 6;
    localparam int unsigned ZW = 4;

    typedef enum logic [1:0] {
        SCAN   = 2'd0,
        COMMIT = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            vblnk_q;
    logic [PW-1:0]   xs_q, ys_q;
    logic [PW-1:0]   xs_eff_c, ys_eff_c;
    logic            fall_c;

    logic [SW-1:0]   h_c, v_c, x_lo_c, x_hi_c, y_lo_c, y_hi_c;
    logic            in_box_c;
    logic [ZW-1:0]   zone_c;

    logic [ZW-1:0]   s1_zone_q;
    logic            s1_terr_q, s1_pad_q, s1_started_q, vblnk_d_q;

    logic [ZW-1:0]   stk_q, stk_d;
    logic [CW-1:0]   pad_ctr_q, pad_ctr_d;
    logic            bad_q, bad_d;
    logic [ZW-1:0]   col_q, col_d;
    logic            landed_q, landed_d;
    logic            hit_c;

    // Snapshot is taken on the vblnk fall; the falling-edge pixel already sees the new position.
    assign fall_c   = vblnk_q & ~vblnk;
    assign xs_eff_c = fall_c ? x_pos : xs_q;
    assign ys_eff_c = fall_c ? y_pos : ys_q;

    // Box and edge-zone decode in 13-bit space so boxes near the screen edge clip instead of wrapping.
    always_comb begin
        h_c      = SW'(hcount);
        v_c      = SW'(vcount);
        x_lo_c   = SW'(xs_eff_c);
        y_lo_c   = SW'(ys_eff_c);
        x_hi_c   = x_lo_c + SW'(ROCKET_WIDTH);
        y_hi_c   = y_lo_c + SW'(ROCKET_HIGH);
        in_box_c = (h_c >= x_lo_c) && (h_c < x_hi_c) && (v_c >= y_lo_c) && (v_c < y_hi_c);
        zone_c   = '0;
        if (in_box_c) begin
            zone_c[3] = v_c <  (y_lo_c + SW'(EDGE));
            zone_c[2] = v_c >= (y_hi_c - SW'(EDGE));
            zone_c[1] = h_c <  (x_lo_c + SW'(EDGE));
            zone_c[0] = h_c >= (x_hi_c - SW'(EDGE));
        end
    end

    // Snapshot register and stage-1 pixel pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vblnk_q      <= 1'b0;
            xs_q         <= '0;
            ys_q         <= '0;
            s1_zone_q    <= '0;
            s1_terr_q    <= 1'b0;
            s1_pad_q     <= 1'b0;
            s1_started_q <= 1'b0;
            vblnk_d_q    <= 1'b0;
        end else begin
            vblnk_q      <= vblnk;
            xs_q         <= xs_eff_c;
            ys_q         <= ys_eff_c;
            s1_zone_q    <= zone_c;
            s1_terr_q    <= terrain;
            s1_pad_q     <= pad;
            s1_started_q <= started;
            vblnk_d_q    <= vblnk;
        end
    end

    // FSM state, accumulators and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SCAN;
            stk_q     <= '0;
            pad_ctr_q <= '0;
            bad_q     <= 1'b0;
            col_q     <= '0;
            landed_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            stk_q     <= stk_d;
            pad_ctr_q <= pad_ctr_d;
            bad_q     <= bad_d;
            col_q     <= col_d;
            landed_q  <= landed_d;
        end
    end

    assign hit_c = s1_terr_q & ~s1_pad_q;

    // Next-state: accumulate during SCAN, publish and clear in COMMIT, idle in HOLD.
    always_comb begin
        state_d   = state_q;
        stk_d     = stk_q;
        pad_ctr_d = pad_ctr_q;
        bad_d     = bad_q;
        col_d     = col_q;
        landed_d  = landed_q;
        unique case (state_q)
            SCAN: begin
                if (vblnk_d_q) begin
                    state_d = COMMIT;
                end else if (s1_started_q) begin
                    stk_d = stk_q | (s1_zone_q & {ZW{hit_c}});
                    if (s1_zone_q[2] && hit_c) begin
                        bad_d = 1'b1;
                    end
                    if (s1_zone_q[2] && s1_pad_q && (pad_ctr_q != '1)) begin
                        pad_ctr_d = pad_ctr_q + CW'(1);
                    end
                end
            end
            COMMIT: begin
                landed_d  = landed_q | (started && (pad_ctr_q >= CW'(PAD_MIN_HITS)) && !bad_q);
                col_d     = (started && !landed_d) ? stk_q : '0;
                stk_d     = '0;
                pad_ctr_d = '0;
                bad_d     = 1'b0;
                state_d   = HOLD;
            end
            HOLD: begin
                if (!vblnk) begin
                    state_d = SCAN;
                end
            end
            default: begin
                state_d = SCAN;
            end
        endcase
    end

    assign colission_up    = col_q[3];
    assign colission_down  = col_q[2];
    assign colission_left  = col_q[1];
    assign colission_right = col_q[0];
    assign landed          = landed_q;

endmodule

// File: tb/tb_rocket_collision_ctl.sv
// Bench for rocket_collision_ctl: directed and random frames against a per-frame reference model.
module tb_rocket_collision_ctl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [10:0] hcount = '0;
    logic [10:0] vcount = '0;
    logic        vblnk = 1'b1;
    logic        terrain = 1'b0;
    logic        pad = 1'b0;
    logic        started = 1'b0;
    logic [11:0] x_pos = '0;
    logic [11:0] y_pos = '0;
    logic        colission_up, colission_down, colission_left, colission_right, landed;

    int checks = 0;
    int errors = 0;
    int frame_no = 0;

    typedef struct {
        int h;
        int v;
        bit t;
        bit p;
    } px_t;

    px_t pq[$];

    bit m_up, m_down, m_left, m_right, m_landed;

    always #5 clk = ~clk;

    rocket_collision_ctl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .hcount          (hcount),
        .vcount          (vcount),
        .vblnk           (vblnk),
        .terrain         (terrain),
        .pad             (pad),
        .started         (started),
        .x_pos           (x_pos),
        .y_pos           (y_pos),
        .colission_up    (colission_up),
        .colission_down  (colission_down),
        .colission_left  (colission_left),
        .colission_right (colission_right),
        .landed          (landed)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s frame=%0d observed=%b expected=%b", tag, frame_no, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_up"},     colission_up,    m_up);
        chk({tag, "_down"},   colission_down,  m_down);
        chk({tag, "_left"},   colission_left,  m_left);
        chk({tag, "_right"},  colission_right, m_right);
        chk({tag, "_landed"}, landed,          m_landed);
    endtask

    task automatic add(input int h, input int v, input bit t, input bit p);
        px_t e;
        e.h = h; e.v = v; e.t = t; e.p = p;
        pq.push_back(e);
    endtask

    // Reference: judge the whole frame from the rules, then apply the commit.
    task automatic model_frame(input int xs, input int ys, input bit st);
        bit fu = 0, fd = 0, fl = 0, fr = 0, bad = 0;
        int pc = 0;
        foreach (pq[i]) begin
            int h = pq[i].h;
            int v = pq[i].v;
            bit inb = (h >= xs) && (h < xs + 48) && (v >= ys) && (v < ys + 64);
            bit hit = pq[i].t && !pq[i].p;
            bit bot = inb && (v >= ys + 60);
            if (!st || !inb) continue;
            if (hit && v < ys + 4)   fu = 1;
            if (hit && bot)          begin fd = 1; bad = 1; end
            if (hit && h < xs + 4)   fl = 1;
            if (hit && h >= xs + 44) fr = 1;
            if (bot && pq[i].p && pc < 63) pc++;
        end
        if (st && pc >= 16 && !bad) m_landed = 1;
        if (!st || m_landed) begin
            m_up = 0; m_down = 0; m_left = 0; m_right = 0;
        end else begin
            m_up = fu; m_down = fd; m_left = fl; m_right = fr;
        end
    endtask

    // Drive one active frame then a vblank, and compare the committed flags.
    task automatic run_frame(input string tag, input int xp, input int yp, input bit st,
                             input int xchg);
        frame_no++;
        x_pos   = 12'(xp);
        y_pos   = 12'(yp);
        started = st;
        pq.push_front('{h: 0, v: 0, t: 1'b0, p: 1'b0});
        foreach (pq[i]) begin
            @(negedge clk);
            vblnk   = 1'b0;
            hcount  = 11'(pq[i].h);
            vcount  = 11'(pq[i].v);
            terrain = pq[i].t;
            pad     = pq[i].p;
            if (xchg >= 0 && i == pq.size() / 2) x_pos = 12'(xchg);
        end
        @(negedge clk);
        vblnk   = 1'b1;
        terrain = 1'b0;
        pad     = 1'b0;
        repeat (6) @(negedge clk);
        model_frame(xp, yp, st);
        chk_all(tag);
        pq.delete();
    endtask

    initial begin
        // Asynchronous reset without any clock edge.
        #1 rst_n = 1'b0;
        #1;
        m_up = 0; m_down = 0; m_left = 0; m_right = 0; m_landed = 0;
        chk_all("rst0");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Random frames around random box positions, including clipped boxes.
        for (int f = 0; f < 30; f++) begin
            int xp = int'($urandom_range(0, 799));
            int yp = int'($urandom_range(0, 599));
            bit st = ($urandom_range(0, 4) != 0);
            for (int k = 0; k < 40; k++) begin
                int h = xp + int'($urandom_range(0, 51)) - 2;
                int v = yp + int'($urandom_range(0, 67)) - 2;
                if (h < 0) h = 0;
                if (v < 0) v = 0;
                if (h > 2047) h = 2047;
                if (v > 2047) v = 2047;
                add(h, v, ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
            end
            run_frame("rand", xp, yp, st, -1);
        end

        // Directed cases with the box at (100,100).
        add(103, 130, 1, 0);           run_frame("left",   100, 100, 1, -1);
        add(10, 10, 0, 0);             run_frame("clean",  100, 100, 1, -1);
        add(147, 163, 1, 0);           run_frame("corner", 100, 100, 1, -1);
        add(99, 100, 1, 0);            run_frame("outside",100, 100, 1, -1);
        add(103, 130, 1, 0);           run_frame("st0_l",  100, 100, 0, -1);
        add(147, 163, 1, 0);           run_frame("st0_c",  100, 100, 0, -1);
        add(120, 101, 1, 0);           run_frame("top",    100, 100, 1, -1);
        add(120, 101, 1, 1);           run_frame("padovr", 100, 100, 1, -1);
        add(5, 5, 0, 0); add(103, 130, 1, 0);
        run_frame("xchg", 100, 100, 1, 300);
        add(103, 130, 1, 0);           run_frame("moved",  300, 100, 1, -1);
        for (int c = 100; c < 115; c++) add(c, 163, 0, 1);
        run_frame("pad15", 100, 100, 1, -1);
        for (int c = 100; c < 120; c++) add(c, 163, 0, 1);
        add(110, 162, 1, 0);
        run_frame("padbad", 100, 100, 1, -1);
        for (int c = 100; c < 116; c++) add(c, 163, 0, 1);
        run_frame("pad16_st0", 100, 100, 0, -1);
        for (int c = 100; c < 116; c++) add(c, 163, 0, 1);
        run_frame("pad16", 100, 100, 1, -1);
        add(103, 130, 1, 0); add(147, 163, 1, 0);
        run_frame("after_land", 100, 100, 1, -1);
        add(10, 10, 0, 0);             run_frame("still_land", 100, 100, 1, -1);

        // Mid-frame reset clears everything immediately.
        frame_no++;
        vblnk = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            hcount = 11'(100 + k); vcount = 11'(130); terrain = 1'b1;
        end
        #2 rst_n = 1'b0;
        #1;
        m_up = 0; m_down = 0; m_left = 0; m_right = 0; m_landed = 0;
        chk_all("rst_mid");
        @(negedge clk);
        vblnk = 1'b1; terrain = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk_all("post_rst");

        add(103, 130, 1, 0);           run_frame("relearn", 100, 100, 1, -1);
        for (int c = 100; c < 170; c++) add(c % 148, 163, 0, 1);
        run_frame("padsat", 100, 100, 1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
